// File: rtl/tdmrc_pkg.sv
// Shared types and constants for the E-TDMRC cipher output path.
package tdmrc_pkg;

  localparam int TDMRC_BLOCK_BYTES = 5;
  localparam int TDMRC_BLOCK_W     = 40;

  typedef logic [7:0]               tdmrc_byte_t;
  typedef logic [TDMRC_BLOCK_W-1:0] tdmrc_block_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CHK
  } tdmrc_state_t;

endpackage

// File: rtl/tdmrc_blk_fifo.sv
// Block buffer: DEPTH entries of one 40-bit cipher block each.
// The head entry is presented combinationally. A push while full is
// accepted only when the head is popped on the same edge.
module tdmrc_blk_fifo
  import tdmrc_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  tdmrc_block_t             wr_data,
  input  logic                     pop,
  output tdmrc_block_t             rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [AW:0]       LVL_FULL = (AW+1)'(DEPTH);

  tdmrc_block_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rd_data = mem[rd_ptr];

  // Storage write; block data carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tdmrc_cipher_serializer.sv
// Captures cipher blocks on the rising edge of the core's done level,
// buffers them and streams each as bytes (MSB byte first) over a
// valid/ready link, optionally followed by an XOR checksum byte.
module tdmrc_cipher_serializer
  import tdmrc_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int APPEND_CHK = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [39:0]            blk_in,
  input  logic                   blk_valid,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int          LW       = $clog2(DEPTH) + 1;
  localparam logic [2:0]  IDX_LAST = 3'(TDMRC_BLOCK_BYTES - 1);

  tdmrc_state_t state, state_nx;
  logic [2:0]   idx, idx_nx;
  logic         blk_valid_q;
  logic         cap;
  logic         xfer;
  logic         pop;
  logic         more;
  logic         ovf_set;
  logic         fifo_full;
  logic         fifo_empty;
  tdmrc_block_t head;

  // Byte i of a block, byte 0 being the most significant.
  function automatic tdmrc_byte_t blk_byte(input tdmrc_block_t b, input logic [2:0] i);
    case (i)
      3'd0:    blk_byte = b[39:32];
      3'd1:    blk_byte = b[31:24];
      3'd2:    blk_byte = b[23:16];
      3'd3:    blk_byte = b[15:8];
      default: blk_byte = b[7:0];
    endcase
  endfunction

  // XOR checksum over the five cipher bytes.
  function automatic tdmrc_byte_t blk_xor(input tdmrc_block_t b);
    blk_xor = b[39:32] ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction

  assign cap     = blk_valid & ~blk_valid_q;
  assign xfer    = out_valid & out_ready;
  assign pop     = xfer & out_last;
  // A block other than the head is waiting, so the next one follows without a bubble.
  assign more    = (level > LW'(1));
  // Drop only when full and the head is not leaving on this edge.
  assign ovf_set = cap & fifo_full & ~pop;

  tdmrc_blk_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (cap),
    .wr_data (blk_in),
    .pop     (pop),
    .rd_data (head),
    .level   (level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Control registers: done edge detector, FSM, byte index, sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_valid_q <= 1'b0;
      state       <= IDLE;
      idx         <= '0;
      overflow    <= 1'b0;
    end else begin
      blk_valid_q <= blk_valid;
      state       <= state_nx;
      idx         <= idx_nx;
      if (ovf_set)        overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Next-state and output decode; outputs depend only on state, idx and head.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_nx = SEND;
          idx_nx   = '0;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = blk_byte(head, idx);
        out_last  = (APPEND_CHK == 0) && (idx == IDX_LAST);
        if (out_ready) begin
          if (idx == IDX_LAST) begin
            idx_nx = '0;
            if (APPEND_CHK != 0) state_nx = CHK;
            else                 state_nx = more ? SEND : IDLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      CHK: begin
        out_valid = 1'b1;
        out_data  = blk_xor(head);
        out_last  = 1'b1;
        if (out_ready) begin
          idx_nx   = '0;
          state_nx = more ? SEND : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_tdmrc_cipher_serializer.sv
// Directed bench for tdmrc_cipher_serializer (DEPTH=2, checksum appended).
module tb_tdmrc_cipher_serializer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] blk_in;
  logic        blk_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [1:0]  level;
  logic        overflow;
  logic        clear_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [8:0] xq [$];
  int         tq [$];
  logic       stall_q = 1'b0;
  logic [8:0] held_q  = '0;

  tdmrc_cipher_serializer #(
    .DEPTH      (DEPTH),
    .APPEND_CHK (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_in    (blk_in),
    .blk_valid (blk_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Negedge monitor: records transfers and checks that a stalled byte holds.
  always @(negedge clk) begin
    if (stall_q && !rst) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_data", 64'({out_last, out_data}), 64'(held_q));
    end
    if (!rst && out_valid && out_ready) begin
      xq.push_back({out_last, out_data});
      tq.push_back(cyc);
    end
    stall_q <= !rst && out_valid && !out_ready;
    held_q  <= {out_last, out_data};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_blk(input logic [39:0] b);
    blk_in    = b;
    blk_valid = 1'b1;
    tick(1);
    blk_valid = 1'b0;
    tick(1);
  endtask

  task automatic clear_log();
    xq.delete();
    tq.delete();
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (xq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(8);
    check_eq({tag, "_count"}, 64'(xq.size()), 64'(n));
  endtask

  task automatic check_block(input string tag, input int base, input logic [39:0] b,
                             input logic [7:0] chk);
    logic [39:0] s;
    logic [8:0]  exp;
    logic [63:0] got;
    s = b;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        exp = {1'b0, s[39:32]};
        s   = s << 8;
      end else begin
        exp = {1'b1, chk};
      end
      got = (base + i < xq.size()) ? 64'(xq[base + i]) : 64'hDEAD;
      check_eq($sformatf("%s_b%0d", tag, i), got, 64'(exp));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst       = 1'b1;
    blk_in    = '0;
    blk_valid = 1'b0;
    out_ready = 1'b0;
    clear_ovf = 1'b0;
    tick(2);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_last",  64'(out_last),  64'd0);
    check_eq("rst_data",  64'(out_data),  64'h00);
    check_eq("rst_level", 64'(level),     64'd0);
    check_eq("rst_ovf",   64'(overflow),  64'd0);
    rst = 1'b0;
    tick(2);

    // Single block, done held high for 20 cycles.
    clear_log();
    out_ready = 1'b1;
    blk_in    = 40'h1122334455;
    blk_valid = 1'b1;
    tick(20);
    blk_valid = 1'b0;
    wait_xfers("single", 6, 20);
    check_block("single", 0, 40'h1122334455, 8'h11);
    check_eq("single_level", 64'(level), 64'd0);
    check_eq("single_valid", 64'(out_valid), 64'd0);

    // Back-pressure with ready pattern 1,0,0,1,0,0,...
    clear_log();
    out_ready = 1'b0;
    pulse_blk(40'h1122334455);
    for (int i = 0; i < 40; i++) begin
      out_ready = (i % 3 == 0);
      tick(1);
    end
    out_ready = 1'b1;
    tick(4);
    check_eq("bp_count", 64'(xq.size()), 64'd6);
    check_block("bp", 0, 40'h1122334455, 8'h11);

    // Two stored blocks drain with no bubble.
    clear_log();
    out_ready = 1'b0;
    pulse_blk(40'hAABBCCDDEE);
    pulse_blk(40'h0102030405);
    tick(2);
    check_eq("nb_level", 64'(level), 64'd2);
    out_ready = 1'b1;
    wait_xfers("nb", 12, 40);
    check_block("nb_a", 0, 40'hAABBCCDDEE, 8'hEE);
    check_block("nb_b", 6, 40'h0102030405, 8'h01);
    check_eq("nb_span", (xq.size() == 12) ? 64'(tq[11] - tq[0]) : 64'hDEAD, 64'd11);
    check_eq("nb_level_end", 64'(level), 64'd0);

    // Overflow: third block dropped while full.
    clear_log();
    out_ready = 1'b0;
    pulse_blk(40'h0000000001);
    pulse_blk(40'hFF00FF00FF);
    pulse_blk(40'h5A5A5A5A5A);
    check_eq("ovf_set",   64'(overflow), 64'd1);
    check_eq("ovf_level", 64'(level),    64'd2);
    clear_ovf = 1'b1;
    tick(1);
    clear_ovf = 1'b0;
    check_eq("ovf_clear", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_xfers("ovf", 12, 40);
    check_block("ovf_1", 0, 40'h0000000001, 8'h01);
    check_block("ovf_2", 6, 40'hFF00FF00FF, 8'hFF);

    // Capture while full on the same edge as the head's last transfer.
    clear_log();
    out_ready = 1'b0;
    pulse_blk(40'h0102040810);
    pulse_blk(40'h1111111111);
    check_eq("sim_level_pre", 64'(level), 64'd2);
    out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!(out_valid && out_last) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("sim_found_last", 64'(out_valid && out_last), 64'd1);
    blk_in    = 40'hC0FFEE0123;
    blk_valid = 1'b1;
    @(posedge clk);
    #1;
    blk_valid = 1'b0;
    check_eq("sim_ovf",   64'(overflow), 64'd0);
    check_eq("sim_level", 64'(level),    64'd2);
    wait_xfers("sim", 18, 60);
    check_block("sim_1", 0,  40'h0102040810, 8'h1F);
    check_block("sim_2", 6,  40'h1111111111, 8'h11);
    check_block("sim_3", 12, 40'hC0FFEE0123, 8'hF3);

    // Reset in the middle of a block.
    clear_log();
    out_ready = 1'b1;
    pulse_blk(40'h123456789A);
    k = 0;
    while (xq.size() < 3 && k < 20) begin
      tick(1);
      k++;
    end
    check_eq("mid_progress", 64'(xq.size() >= 3), 64'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid", 64'(out_valid), 64'd0);
    check_eq("mid_rst_last",  64'(out_last),  64'd0);
    check_eq("mid_rst_data",  64'(out_data),  64'h00);
    check_eq("mid_rst_level", 64'(level),     64'd0);
    check_eq("mid_rst_ovf",   64'(overflow),  64'd0);
    tick(2);
    rst = 1'b0;
    tick(1);
    clear_log();
    pulse_blk(40'h0A0B0C0D0E);
    wait_xfers("post", 6, 20);
    check_block("post", 0, 40'h0A0B0C0D0E, 8'h0E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
